line_window_ctrl: RTL and testbench

LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

---
 rtl/line_window_if.sv | 23 ++
 rtl/line_window_ctrl.sv | 114 +++++++++++
 tb/tb_line_window_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/line_window_if.sv
// line_window_if: pixel stream in, 3-line window taps and tagged filter strobes out.
interface line_window_if #(parameter int WIDTH = 24);
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_sof;
  logic             s_ready;
  logic [WIDTH-1:0] row0;
  logic [WIDTH-1:0] row1;
  logic [WIDTH-1:0] row2;
  logic             win_valid;
  logic             m_valid;
  logic             m_eol;
  logic             m_eof;
  logic             frame_done;
  modport slave (
    input  s_valid, s_data, s_sof,
    output s_ready, row0, row1, row2, win_valid, m_valid, m_eol, m_eof, frame_done
  );
  modport master (
    output s_valid, s_data, s_sof,
    input  s_ready, row0, row1, row2, win_valid, m_valid, m_eol, m_eof, frame_done
  );
endinterface

// File: rtl/line_window_ctrl.sv
// line_window_ctrl: two-line-buffer 3x3 window sequencer with flush and output position tagging.
// Define LINE_WINDOW_SOF_RESYNC_EN to let s_sof restart a frame while in FILL or RUN.
module line_window_ctrl #(
  parameter int WIDTH      = 24,
  parameter int PIC_WIDTH  = 320,
  parameter int PIC_HEIGHT = 240,
  parameter int FILT_LAT   = 2
) (
  input logic          clk,
  input logic          rst_n,
  line_window_if.slave bus
);
  localparam int CW = $clog2(PIC_WIDTH);
  localparam int RW = $clog2(PIC_HEIGHT);
  localparam int FW = FILT_LAT > 1 ? $clog2(FILT_LAT) : 1;
  localparam int TW = 1 + CW + RW;
  localparam logic [CW-1:0] C_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(PIC_HEIGHT - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FILT_LAT - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_col, w_c, w_tcol;
  logic [RW-1:0] r_row, w_trow;
  logic [FW-1:0] r_fcnt;
  logic [WIDTH-1:0] r_lb0 [PIC_WIDTH];
  logic [WIDTH-1:0] r_lb1 [PIC_WIDTH];
  logic [WIDTH-1:0] r_row0, r_row1, r_row2;
  logic [TW-1:0] r_cur, w_old;
  logic [TW-1:0] r_tag [FILT_LAT];
  logic r_win_valid, r_done_pend, r_frame_done;
  logic w_acc, w_take, w_sof, w_eol, w_last, w_flush_end, w_tv;

  assign bus.s_ready = r_state != FLUSH;
  assign w_acc = bus.s_valid && bus.s_ready;
`ifdef LINE_WINDOW_SOF_RESYNC_EN
  assign w_sof = w_acc && bus.s_sof;
`else
  assign w_sof = w_acc && bus.s_sof && r_state == IDLE;
`endif
  assign w_take = w_acc && (r_state != IDLE || bus.s_sof);
  assign w_c = w_sof ? '0 : r_col;
  assign w_eol = r_col == C_LAST;
  assign w_last = w_eol && r_row == R_LAST;
  assign w_flush_end = r_state == FLUSH && r_fcnt == F_LAST;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (w_sof) w_next = FILL;
    else if (w_take && w_eol && r_state == FILL && r_row == RW'(1)) w_next = RUN;
    else if (w_take && w_last && r_state == RUN) w_next = FLUSH;
    else if (w_flush_end) w_next = IDLE;
  end

  // Line buffers are never reset; FILL rewrites both before RUN reads them.
  always_ff @(posedge clk)
    if (w_take) begin
      r_lb0[w_c] <= r_lb1[w_c];
      r_lb1[w_c] <= bus.s_data;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_fcnt       <= '0;
      r_row0       <= '0;
      r_row1       <= '0;
      r_row2       <= '0;
      r_cur        <= '0;
      r_win_valid  <= 1'b0;
      r_done_pend  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < FILT_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_win_valid  <= (w_take && r_state == RUN && !w_sof) || r_state == FLUSH;
      r_done_pend  <= w_flush_end;
      r_frame_done <= r_done_pend;
      r_fcnt       <= r_state == FLUSH && !w_flush_end ? r_fcnt + 1'b1 : '0;
      if (w_take) begin
        r_col  <= w_sof ? CW'(1) : w_eol ? '0 : r_col + 1'b1;
        r_row  <= w_sof ? '0 : !w_eol ? r_row : w_last ? '0 : r_row + 1'b1;
        r_row0 <= r_lb0[w_c];
        r_row1 <= r_lb1[w_c];
        r_row2 <= bus.s_data;
      end
      // Flush beats carry an invalid tag so nothing past the frame end is reported.
      if (r_state == FLUSH) r_cur <= '0;
      else if (w_take) r_cur <= {1'b1, w_c, r_row};
      if (w_sof) for (int i = 0; i < FILT_LAT; i++) r_tag[i] <= '0;
      else if (r_win_valid) begin
        for (int i = FILT_LAT - 1; i > 0; i--) r_tag[i] <= r_tag[i-1];
        r_tag[0] <= r_cur;
      end
    end

  assign w_old  = r_tag[FILT_LAT-1];
  assign w_tv   = w_old[TW-1];
  assign w_tcol = w_old[RW +: CW];
  assign w_trow = w_old[RW-1:0];

  assign bus.row0       = r_row0;
  assign bus.row1       = r_row1;
  assign bus.row2       = r_row2;
  assign bus.win_valid  = r_win_valid;
  assign bus.m_valid    = r_win_valid && w_tv && w_tcol >= CW'(2);
  assign bus.m_eol      = bus.m_valid && w_tcol == C_LAST;
  assign bus.m_eof      = bus.m_eol && w_trow == R_LAST;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_line_window_ctrl.sv
// tb_line_window_ctrl: scoreboard bench; window taps and m_* flags predicted per driven pixel.
module tb_line_window_ctrl;
  localparam int PW = 8;
  localparam int PH = 6;
  logic clk = 0;
  logic rst_n = 0;
  int n_checks = 0;
  int n_errs = 0;
  int m_cnt = 0, eol_cnt = 0, eof_cnt = 0;
  logic [23:0] win_q [$];
  logic [1:0]  m_q [$];

  line_window_if #(.WIDTH(8)) bus ();
  line_window_ctrl #(.WIDTH(8), .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .FILT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] px(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  task automatic expect_px(input int r, input int c, inout logic [23:0] last_w);
    if (r >= 2) begin
      last_w = {px(r - 2, c), px(r - 1, c), px(r, c)};
      win_q.push_back(last_w);
      if (c >= 2) m_q.push_back({c == PW - 1, c == PW - 1 && r == PH - 1});
    end
  endtask

  task automatic send(input bit gap, input logic [7:0] d, input logic sof);
    int g = 0;
    while (gap && $urandom_range(1, 0) == 1) begin
      bus.s_valid = 0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1; bus.s_data = d; bus.s_sof = sof;
    while (!bus.s_ready) begin
      @(posedge clk); #1;
      g++;
      if (g > 50) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    bus.s_valid = 0; bus.s_sof = 0;
  endtask

  task automatic run_frame(input bit gap, input int ab_r, input int ab_c);
    int p = 0;
    int r, c;
    bit ab = ab_r >= 0;
    logic [23:0] last_w = '0;
    m_cnt = 0; eol_cnt = 0; eof_cnt = 0;
    while (p < PW * PH) begin
      r = p / PW; c = p % PW;
      if (ab && r == ab_r && c == ab_c) begin
        ab = 0;
`ifdef LINE_WINDOW_SOF_RESYNC_EN
        send(gap, px(0, 0), 1'b1);
        win_q.delete(); m_q.delete();
        m_cnt = 0; eol_cnt = 0; eof_cnt = 0;
        p = 1;
`else
        expect_px(r, c, last_w);
        send(gap, px(r, c), 1'b1);
        p++;
`endif
        continue;
      end
      expect_px(r, c, last_w);
      send(gap, px(r, c), p == 0);
      p++;
    end
    win_q.push_back(last_w);
    win_q.push_back(last_w);
    @(negedge clk); check("flush_rdy1", bus.s_ready, 0);
    @(negedge clk); check("flush_rdy2", bus.s_ready, 0); check("done_early", bus.frame_done, 0);
    @(negedge clk); check("idle_rdy", bus.s_ready, 1); check("done_early2", bus.frame_done, 0);
    @(negedge clk); check("frame_done", bus.frame_done, 1);
    @(negedge clk); check("done_pulse", bus.frame_done, 0);
    check("win_q_left", win_q.size(), 0);
    check("m_q_left", m_q.size(), 0);
    check("m_count", m_cnt, (PH - 2) * (PW - 2));
    check("eol_count", eol_cnt, PH - 2);
    check("eof_count", eof_cnt, 1);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (bus.win_valid) begin
      if (win_q.size() == 0) check("win_unexp", 1, 0);
      else check("win_taps", {bus.row0, bus.row1, bus.row2}, win_q.pop_front());
    end
    if (bus.m_valid) begin
      m_cnt++;
      eol_cnt += int'(bus.m_eol);
      eof_cnt += int'(bus.m_eof);
      if (m_q.size() == 0) check("m_unexp", 1, 0);
      else check("m_flags", {bus.m_eol, bus.m_eof}, m_q.pop_front());
    end else if (bus.m_eol || bus.m_eof) check("m_flags_nv", {bus.m_eol, bus.m_eof}, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] lw = '0;
    bus.s_valid = 0; bus.s_data = 0; bus.s_sof = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_ready", bus.s_ready, 1);
    check("rst_win", bus.win_valid, 0);
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_taps", {bus.row0, bus.row1, bus.row2}, 0);
    check("rst_done", bus.frame_done, 0);
    for (int i = 0; i < 4; i++) send(0, 8'hAA, 1'b0);
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    run_frame(0, 3, 5);
    for (int p = 0; p < 3 * PW + 3; p++) begin
      expect_px(p / PW, p % PW, lw);
      send(0, px(p / PW, p % PW), p == 0);
    end
    rst_n = 0;
    win_q.delete(); m_q.delete();
    #1;
    check("mid_rst_win", bus.win_valid, 0);
    check("mid_rst_m", {bus.m_valid, bus.m_eol, bus.m_eof}, 0);
    check("mid_rst_taps", {bus.row0, bus.row1, bus.row2}, 0);
    check("mid_rst_done", bus.frame_done, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("rel_ready", bus.s_ready, 1);
    for (int i = 0; i < 2 * PW + 2; i++) send(0, 8'h33, 1'b0);
    repeat (4) @(negedge clk);
    run_frame(1, -1, -1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
